// File: rtl/weight_sram_loader_if.sv
// Host/DMA weight stream, load control and weight SRAM write port of the loader.
interface weight_sram_loader_if #(
  parameter int unsigned FV_SIZE         = 16,
  parameter int unsigned MULT_PER_PE     = 4,
  parameter int unsigned MAX_LAYERS      = 4,
  parameter int unsigned LINES_PER_LAYER = 32
);
  localparam int unsigned SRAM_BW = FV_SIZE * MULT_PER_PE;
  localparam int unsigned LW      = $clog2(MAX_LAYERS);
  localparam int unsigned LNW     = $clog2(LINES_PER_LAYER);
  localparam int unsigned MAX_FV  = LINES_PER_LAYER * MULT_PER_PE;
  localparam int unsigned NFW     = $clog2(MAX_FV) + 1;

  logic               start;
  logic [LW-1:0]      num_layer;
  logic [NFW-1:0]     num_fv;
  logic               in_valid;
  logic [FV_SIZE-1:0] in_data;
  logic               in_ready;
  logic               sram_cen;
  logic               sram_wen;
  logic [LW+LNW-1:0]  sram_a;
  logic [SRAM_BW-1:0] sram_d;
  logic               busy;
  logic               done;
  logic               err;

  // Host side: issues the load request and the element stream.
  modport master (
    output start, num_layer, num_fv, in_valid, in_data,
    input  in_ready, sram_cen, sram_wen, sram_a, sram_d, busy, done, err
  );

  // Loader side.
  modport slave (
    input  start, num_layer, num_fv, in_valid, in_data,
    output in_ready, sram_cen, sram_wen, sram_a, sram_d, busy, done, err
  );
endinterface

// File: rtl/weight_sram_loader.sv
// Packs 16-bit weight elements four per 64-bit word and writes them to the
// weight SRAM at {layer, line}, the same layout the weight read controller walks.
module weight_sram_loader (
  input logic                 clk,
  input logic                 reset,
  weight_sram_loader_if.slave ld
);
  localparam int unsigned FV_SIZE         = 16;
  localparam int unsigned MULT_PER_PE     = 4;
  localparam int unsigned MAX_LAYERS      = 4;
  localparam int unsigned LINES_PER_LAYER = 32;
  localparam int unsigned SRAM_BW = FV_SIZE * MULT_PER_PE;
  localparam int unsigned LW      = $clog2(MAX_LAYERS);
  localparam int unsigned LNW     = $clog2(LINES_PER_LAYER);
  localparam int unsigned MAX_FV  = LINES_PER_LAYER * MULT_PER_PE;
  localparam int unsigned NFW     = $clog2(MAX_FV) + 1;
  localparam int unsigned LANEW   = $clog2(MULT_PER_PE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [LANEW-1:0]   lane_q, lane_d;
  logic [LNW-1:0]     line_q, line_d;
  logic [LNW-1:0]     last_line_q, last_line_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [LW-1:0]      num_layer_q, num_layer_d;
  logic [SRAM_BW-1:0] pack_q, pack_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cen_q, cen_d;
  logic               wen_q, wen_d;
  logic [LW+LNW-1:0]  a_q, a_d;
  logic [SRAM_BW-1:0] d_q, d_d;
  logic               cfg_ok;
  logic               xfer;

  // Next-state, packing and SRAM strobe generation.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    line_d      = line_q;
    last_line_d = last_line_q;
    layer_d     = layer_q;
    num_layer_d = num_layer_q;
    pack_d      = pack_q;
    err_d       = 1'b0;
    cen_d       = 1'b1;
    wen_d       = 1'b1;
    a_d         = '0;
    d_d         = '0;

    cfg_ok = (ld.num_fv != '0) && (ld.num_fv[LANEW-1:0] == '0) &&
             (ld.num_fv <= NFW'(MAX_FV));
    xfer   = (state_q == ST_LOAD) && ld.in_valid && in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (ld.start) begin
          if (cfg_ok) begin
            num_layer_d = ld.num_layer;
            last_line_d = LNW'((ld.num_fv >> LANEW) - NFW'(1));
            lane_d      = '0;
            line_d      = '0;
            layer_d     = '0;
            pack_d      = '0;
            state_d     = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          for (int i = 0; i < int'(MULT_PER_PE); i++) begin
            if (lane_q == LANEW'(i)) pack_d[i*FV_SIZE +: FV_SIZE] = ld.in_data;
          end
          lane_d = lane_q + LANEW'(1);
          // Word complete: present it next cycle and advance line/layer.
          if (lane_q == LANEW'(MULT_PER_PE - 1)) begin
            cen_d = 1'b0;
            wen_d = 1'b0;
            a_d   = {layer_q, line_q};
            d_d   = pack_d;
            if (line_q == last_line_q) begin
              line_d  = '0;
              layer_d = layer_q + LW'(1);
              if (layer_q == num_layer_q) state_d = ST_DONE;
            end else begin
              line_d = line_q + LNW'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_DONE);
  end

  // State and registered outputs; synchronous reset drops any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      line_q      <= '0;
      last_line_q <= '0;
      layer_q     <= '0;
      num_layer_q <= '0;
      pack_q      <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      line_q      <= line_d;
      last_line_q <= last_line_d;
      layer_q     <= layer_d;
      num_layer_q <= num_layer_d;
      pack_q      <= pack_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
    end
  end

  assign ld.in_ready = in_ready_q;
  assign ld.busy     = busy_q;
  assign ld.done     = done_q;
  assign ld.err      = err_q;
  assign ld.sram_cen = cen_q;
  assign ld.sram_wen = wen_q;
  assign ld.sram_a   = a_q;
  assign ld.sram_d   = d_q;
endmodule

// File: doc/weight_sram_loader.md
# weight_sram_loader

Write-side companion of the weight read controller: accepts a stream of 16-bit weight elements, packs four per 64-bit word (lane 0 in bits [15:0]) and writes them into the weight SRAM at address {layer, line}. This is the same layout the read controller walks. It sits between the host/DMA weight stream and the weight SRAM port. It holds `busy` high while it owns the port, so the read controller must not be fired until `done`.

## Interface
- FV_SIZE, 16, bits per weight element
- MULT_PER_PE, 4, elements packed per SRAM word
- SRAM_BW, 64, SRAM data width (= FV_SIZE*MULT_PER_PE)
- MAX_LAYERS, 4, weight layers; layer field LW = clog2(MAX_LAYERS)
- LINES_PER_LAYER, 32, SRAM lines per layer; line field LNW = clog2(LINES_PER_LAYER)
- MAX_FV, 128, max elements per layer (= LINES_PER_LAYER*MULT_PER_PE)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a load
- num_layer  in  LW  number of layers minus 1; sampled on accepted start
- num_fv  in  clog2(MAX_FV)+1  elements per layer; sampled on accepted start
- in_valid  in  1  element valid
- in_data  in  FV_SIZE  weight element
- in_ready  out  1  loader accepts element this cycle
- sram_cen  out  1  chip enable, active-low
- sram_wen  out  1  write enable, active-low
- sram_a  out  LW+LNW  address {layer, line}
- sram_d  out  SRAM_BW  write data
- busy  out  1  loader owns the SRAM port
- done  out  1  one-cycle pulse after the final write
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, LOAD, DONE.
- IDLE, start=1:
  - If num_fv is 0, num_fv is not a multiple of MULT_PER_PE, or num_fv > MAX_FV: err=1 next cycle, stay IDLE.
  - Otherwise latch num_layer and num_fv, clear lane/line/layer counters, and go to LOAD.
- start outside IDLE is ignored; no err.
- LOAD:
  - in_ready=1 every cycle; there is no backpressure from the SRAM.
  - A transfer occurs when in_valid & in_ready. The element is written to the pack register at lane `lane`, bits [16*lane+15 : 16*lane], and lane increments.
  - On the transfer at lane=MULT_PER_PE-1, the next cycle presents the SRAM write: sram_cen=0, sram_wen=0, sram_a={layer,line}, sram_d=packed word. lane wraps to 0.
  - After each word, line increments. When line = num_fv/MULT_PER_PE-1, line wraps to 0 and layer increments.
  - After the word with layer=num_layer at the last line, in_ready drops in the same cycle the write is presented, and the state moves to DONE.
- DONE: one cycle; outputs done=1, busy=0; then IDLE.
- Only full words are written; there are no partial writes.
- Arithmetic is unsigned. Counters are sized to their fields, so line never exceeds LINES_PER_LAYER-1.
- Idle port values: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.

## Timing
- All outputs are registered.
- Reset values:
  - in_ready=0, busy=0, done=0, err=0
  - sram_cen=1, sram_wen=1, sram_a=0, sram_d=0
  - state=IDLE; counters and pack register cleared
- start accepted at edge N: busy=1 and in_ready=1 from cycle N+1.
- Write latency: the SRAM strobe appears exactly one cycle after the transfer that completes a word. It lasts one cycle.
- Back-to-back transfers sustain one word per MULT_PER_PE cycles.
- Gaps in in_valid stall packing with no effect on state; lane is held.
- Last write strobe is at cycle M; done=1 and busy=0 at cycle M+1; in_ready=0 from cycle M.
- Reset mid-load:
  - All outputs return to reset values at the next edge.
  - The partial word is discarded and no write is issued.
  - The SRAM write in the same cycle as reset is suppressed (cen=1).
- start together with reset is ignored.

## Test plan
- Reset: hold reset 3 cycles while driving start=1 and in_valid=1 -> all outputs at reset values, no SRAM strobe, busy=0.
- Single layer, 8 elements: start with num_layer=0, num_fv=8, feed 0x0001..0x0008 back-to-back -> writes at A=0x00 with D=0x0004_0003_0002_0001 and at A=0x01 with D=0x0008_0007_0006_0005; done one cycle after the second strobe; exactly 2 strobes.
- Multi-layer wrap: num_layer=2, num_fv=4, feed 12 elements -> writes at A=0x00, 0x20, 0x40; in_ready=0 after the 12th transfer; extra in_valid is ignored.
- Stalled stream: num_fv=4 with in_valid toggling 1,0,0,1,1,0,1 -> one write containing the 4 accepted elements in order; strobe exactly one cycle after the 4th transfer.
- Bad config: start with num_fv=6, then num_fv=0, then num_fv=132 -> err pulse for each; busy stays 0; no writes.
- Reset mid-load: num_fv=8; reset after 6 transfers -> only the A=0x00 write occurred; no write to A=0x01; a subsequent load with num_fv=4 writes cleanly to A=0x00.
